vend_ctrl: RTL and testbench

VEND_CTRL -- requirements
Module: vend_ctrl

---
 rtl/vend_ctrl.sv | 118 +++++++++++
 tb/tb_vend_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vend_ctrl.sv
// Vending machine controller: coin credit, item purchase with per-item stock,
// dispenser handshake and change return one 5-unit pulse per cycle.
module vend_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] coin,
  input  logic [1:0] sel,
  input  logic       sel_vld,
  input  logic       cancel,
  input  logic       restock,
  input  logic       disp_ack,
  output logic       disp_req,
  output logic [1:0] disp_item,
  output logic       chg5,
  output logic [2:0] credit,
  output logic       coin_rej,
  output logic       sold_out,
  output logic       busy
);

  localparam int unsigned CW         = 3;
  localparam int unsigned MAX_CREDIT = 6;
  localparam int unsigned NUM_ITEMS  = 4;

  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

  state_t        state;
  logic [1:0]    stock [NUM_ITEMS];
  logic          coin_ok;
  logic [CW-1:0] coin_val;
  logic [CW:0]   coin_sum;
  logic [CW-1:0] price;

  // Coin decode and price lookup (price of item n is n+2 units of 5)
  always_comb begin
    coin_ok  = (coin == 2'b01) || (coin == 2'b10);
    coin_val = '0;
    if (coin == 2'b01) coin_val = CW'(1);
    if (coin == 2'b10) coin_val = CW'(2);
    coin_sum = {1'b0, credit} + {1'b0, coin_val};
    price    = CW'(sel) + CW'(2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      credit    <= '0;
      disp_req  <= 1'b0;
      disp_item <= '0;
      chg5      <= 1'b0;
      coin_rej  <= 1'b0;
      sold_out  <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= 2'd3;
    end else begin
      coin_rej <= 1'b0;
      sold_out <= 1'b0;
      chg5     <= 1'b0;
      case (state)
        IDLE: begin
          // A purchase request outranks both cancel and a coin in the same cycle
          if (sel_vld) begin
            coin_rej <= coin_ok;
            if (stock[sel] == 2'd0) begin
              sold_out <= 1'b1;
            end else if (credit >= price) begin
              credit     <= credit - price;
              stock[sel] <= stock[sel] - 2'd1;
              disp_item  <= sel;
              disp_req   <= 1'b1;
              busy       <= 1'b1;
              state      <= VEND;
            end
          end else if (cancel && (credit != '0)) begin
            coin_rej <= coin_ok;
            busy     <= 1'b1;
            state    <= CHANGE;
          end else if (coin_ok) begin
            if (coin_sum <= (CW+1)'(MAX_CREDIT)) credit <= coin_sum[CW-1:0];
            else                                coin_rej <= 1'b1;
          end
        end
        VEND: begin
          coin_rej <= coin_ok;
          if (disp_ack) begin
            disp_req  <= 1'b0;
            disp_item <= '0;
            if (credit != '0) begin
              state <= CHANGE;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        CHANGE: begin
          // One pulse per remaining unit; the exit cycle itself carries no pulse
          coin_rej <= coin_ok;
          if (credit != '0) begin
            chg5   <= 1'b1;
            credit <= credit - CW'(1);
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
      if (restock) begin
        for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= 2'd3;
      end
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl: per-cycle vector table plus a hand-written
// reset-during-change sequence.
module tb_vend_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] coin;
  logic [1:0] sel;
  logic       sel_vld;
  logic       cancel;
  logic       restock;
  logic       disp_ack;
  logic       disp_req;
  logic [1:0] disp_item;
  logic       chg5;
  logic [2:0] credit;
  logic       coin_rej;
  logic       sold_out;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  vend_ctrl dut (
    .clk(clk), .rst(rst), .coin(coin), .sel(sel), .sel_vld(sel_vld),
    .cancel(cancel), .restock(restock), .disp_ack(disp_ack),
    .disp_req(disp_req), .disp_item(disp_item), .chg5(chg5), .credit(credit),
    .coin_rej(coin_rej), .sold_out(sold_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] coin;
    logic [1:0] sel;
    logic       sel_vld;
    logic       cancel;
    logic       restock;
    logic       disp_ack;
    logic       e_req;
    logic [1:0] e_item;
    logic       e_chg;
    logic [2:0] e_credit;
    logic       e_rej;
    logic       e_so;
    logic       e_busy;
    bit         stk_chk;
    int         stk_idx;
    int         stk_val;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int c, int s, int sv, int cn, int rs, int ak,
                              int rq, int it, int ch, int cr, int rj, int so, int bz,
                              bit sc = 1'b0, int si = 0, int sval = 0);
    vec_t v;
    v.coin = 2'(c);  v.sel = 2'(s);  v.sel_vld = 1'(sv);  v.cancel = 1'(cn);
    v.restock = 1'(rs);  v.disp_ack = 1'(ak);
    v.e_req = 1'(rq);  v.e_item = 2'(it);  v.e_chg = 1'(ch);  v.e_credit = 3'(cr);
    v.e_rej = 1'(rj);  v.e_so = 1'(so);  v.e_busy = 1'(bz);
    v.stk_chk = sc;  v.stk_idx = si;  v.stk_val = sval;
    return v;
  endfunction

  task automatic check(string name, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    coin = 2'd0; sel = 2'd0; sel_vld = 1'b0; cancel = 1'b0; restock = 1'b0; disp_ack = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic buy_item3_rows();
    vecs.push_back(mk(2,0,0,0,0,0, 0,0,0,2,0,0,0));
    vecs.push_back(mk(2,0,0,0,0,0, 0,0,0,4,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0,5,0,0,0));
    vecs.push_back(mk(0,3,1,0,0,0, 1,3,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,0,0));
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;

    // Exact pay: 10+10 buys item 2 with nothing left over
    vecs.push_back(mk(2,0,0,0,0,0, 0,0,0,2,0,0,0));
    vecs.push_back(mk(2,0,0,0,0,0, 0,0,0,4,0,0,0));
    vecs.push_back(mk(0,2,1,0,0,0, 1,2,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0, 1,2,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0, 1'b1, 2, 2));
    // Overpay: credit 5, item 0 costs 2, three change pulses
    vecs.push_back(mk(2,0,0,0,0,0, 0,0,0,2,0,0,0));
    vecs.push_back(mk(2,0,0,0,0,0, 0,0,0,4,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0,5,0,0,0));
    vecs.push_back(mk(0,0,1,0,0,0, 1,0,0,3,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,3,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,1,2,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,1,1,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,1,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0));
    // Saturation at 6, rejection in IDLE and in VEND
    vecs.push_back(mk(2,0,0,0,0,0, 0,0,0,2,0,0,0));
    vecs.push_back(mk(2,0,0,0,0,0, 0,0,0,4,0,0,0));
    vecs.push_back(mk(2,0,0,0,0,0, 0,0,0,6,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0,6,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,6,0,0,0));
    vecs.push_back(mk(0,3,1,0,0,0, 1,3,0,1,0,0,1));
    vecs.push_back(mk(2,0,0,0,0,0, 1,3,0,1,1,0,1));
    vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,1,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,1,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0));
    // Sold out: two more item-3 purchases empty the slot
    buy_item3_rows();
    buy_item3_rows();
    vecs.push_back(mk(2,0,0,0,0,0, 0,0,0,2,0,0,0));
    vecs.push_back(mk(2,0,0,0,0,0, 0,0,0,4,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0,5,0,0,0));
    vecs.push_back(mk(0,3,1,0,0,0, 0,0,0,5,0,1,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,5,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,0, 0,0,0,5,0,0,0, 1'b1, 3, 3));
    vecs.push_back(mk(0,3,1,0,0,0, 1,3,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,0,0, 1'b1, 3, 2));
    // Restock on the same edge as a purchase decrement keeps stock at 3
    vecs.push_back(mk(2,0,0,0,0,0, 0,0,0,2,0,0,0));
    vecs.push_back(mk(2,0,0,0,0,0, 0,0,0,4,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0,5,0,0,0));
    vecs.push_back(mk(0,3,1,0,1,0, 1,3,0,0,0,0,1, 1'b1, 3, 3));
    vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,0,0));
    // Cancel refund, cancel at zero credit, sel_vld+cancel priority
    vecs.push_back(mk(2,0,0,0,0,0, 0,0,0,2,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0,3,0,0,0));
    vecs.push_back(mk(0,0,0,1,0,0, 0,0,0,3,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,1,2,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,1,1,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,1,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,1,0,0, 0,0,0,0,0,0,0));
    vecs.push_back(mk(2,0,0,0,0,0, 0,0,0,2,0,0,0));
    vecs.push_back(mk(2,0,0,0,0,0, 0,0,0,4,0,0,0));
    vecs.push_back(mk(0,1,1,1,0,0, 1,1,0,1,0,0,1));
    vecs.push_back(mk(0,0,0,1,0,0, 1,1,0,1,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,1,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,1,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0));
    // Invalid coin, stray ack in IDLE, insufficient credit with a coin alongside
    vecs.push_back(mk(3,0,0,0,0,0, 0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0,1,0,0,0));
    vecs.push_back(mk(2,3,1,0,0,0, 0,0,0,1,1,0,0));
    vecs.push_back(mk(0,0,0,1,0,0, 0,0,0,1,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,1,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0));

    // Reset state
    #2;
    check("reset_credit", int'(credit), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_outs", int'({disp_req, disp_item, chg5, coin_rej, sold_out}), 0);
    #10;
    rst = 1'b1;
    step();

    foreach (vecs[i]) begin
      coin = vecs[i].coin; sel = vecs[i].sel; sel_vld = vecs[i].sel_vld;
      cancel = vecs[i].cancel; restock = vecs[i].restock; disp_ack = vecs[i].disp_ack;
      step();
      n_tests++;
      if (disp_req !== vecs[i].e_req || disp_item !== vecs[i].e_item ||
          chg5 !== vecs[i].e_chg || credit !== vecs[i].e_credit ||
          coin_rej !== vecs[i].e_rej || sold_out !== vecs[i].e_so ||
          busy !== vecs[i].e_busy) begin
        n_fail++;
        $display("FAIL row %0d: got req=%0b item=%0d chg5=%0b credit=%0d rej=%0b so=%0b busy=%0b expected req=%0b item=%0d chg5=%0b credit=%0d rej=%0b so=%0b busy=%0b",
                 i, disp_req, disp_item, chg5, credit, coin_rej, sold_out, busy,
                 vecs[i].e_req, vecs[i].e_item, vecs[i].e_chg, vecs[i].e_credit,
                 vecs[i].e_rej, vecs[i].e_so, vecs[i].e_busy);
      end
      if (vecs[i].stk_chk) begin
        check($sformatf("stock_row%0d", i), int'(dut.stock[vecs[i].stk_idx]), vecs[i].stk_val);
      end
    end
    idle_inputs();

    // Reset during CHANGE: credit 4, cancel, reset after the first pulse
    coin = 2'd2; step();
    coin = 2'd2; step();
    coin = 2'd0; cancel = 1'b1; step();
    cancel = 1'b0; step();
    check("mid_change_chg5", int'(chg5), 1);
    check("mid_change_credit", int'(credit), 3);
    rst = 1'b0;
    #1;
    check("async_rst_credit", int'(credit), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_chg5", int'(chg5), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    coin = 2'd1;
    step();
    check("post_rst_first_edge_credit", int'(credit), 1);
    coin = 2'd0;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("post_rst_chg5_%0d", k), int'(chg5), 0);
      check($sformatf("post_rst_busy_%0d", k), int'(busy), 0);
    end
    check("post_rst_credit_hold", int'(credit), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
